// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU core with a generic req/ready memory port.
// Executes one instruction per IDLE->FETCH->EXEC pass, plus PTR/DATA for memory operands.
module acc_cpu_param #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  input  logic                  run,
  output logic                  busy,
  output logic                  halt,
  output logic                  trap,
  output logic [ADDR_WIDTH-1:0] pc_out,
  input  logic [OUT_WIDTH-1:0]  data_in,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int unsigned ImmWidth = DATA_WIDTH - 6;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpHalt  = 4'h1;
  localparam logic [3:0] OpLoad  = 4'h2;
  localparam logic [3:0] OpStore = 4'h3;
  localparam logic [3:0] OpAdd   = 4'h4;
  localparam logic [3:0] OpSub   = 4'h5;
  localparam logic [3:0] OpAnd   = 4'h6;
  localparam logic [3:0] OpOr    = 4'h7;
  localparam logic [3:0] OpXor   = 4'h8;
  localparam logic [3:0] OpNot   = 4'h9;
  localparam logic [3:0] OpBr    = 4'hA;
  localparam logic [3:0] OpIf    = 4'hB;
  localparam logic [3:0] OpOut   = 4'hC;
  localparam logic [3:0] OpAdc   = 4'hD;
  localparam logic [3:0] OpIn    = 4'hE;
  localparam logic [3:0] OpTrap  = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StPtr,
    StData,
    StHalt,
    StTrap
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] ea_q, ea_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [OUT_WIDTH-1:0]  dout_q, dout_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;
  logic                  skip_q, skip_d;
  logic                  skipped_q, skipped_d;

  // Instruction fields
  logic [3:0]          op;
  logic [1:0]          mode;
  logic [ImmWidth-1:0] imm;

  assign op   = inst_q[DATA_WIDTH-1 -: 4];
  assign mode = inst_q[DATA_WIDTH-5 -: 2];
  assign imm  = inst_q[ImmWidth-1:0];

  logic [ADDR_WIDTH-1:0] dir_addr, ptr_addr, pc_inc, br_target;
  logic [DATA_WIDTH-1:0] imm_data, din_data;

  assign dir_addr  = ADDR_WIDTH'(imm);
  assign ptr_addr  = ADDR_WIDTH'(mem_rdata);
  assign pc_inc    = pc_q + ADDR_WIDTH'(1);
  assign br_target = pc_inc + ADDR_WIDTH'(signed'(imm));
  assign imm_data  = DATA_WIDTH'(imm);
  assign din_data  = DATA_WIDTH'(data_in);

  logic has_operand, illegal, if_cond;

  always_comb begin
    has_operand = 1'b0;
    case (op)
      OpLoad, OpStore, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpAdc: has_operand = 1'b1;
      default: has_operand = 1'b0;
    endcase
  end

  assign illegal = (op == OpTrap) ||
                   (has_operand && ((mode == 2'd3) || ((op == OpStore) && (mode == 2'd0))));

  always_comb begin
    if_cond = 1'b0;
    case (imm[1:0])
      2'd0:    if_cond = ~zero_q;
      2'd1:    if_cond = zero_q;
      2'd2:    if_cond = ~carry_q;
      default: if_cond = ~skipped_q;
    endcase
  end

  // ALU: operand comes from the immediate in EXEC, from memory in DATA
  logic [DATA_WIDTH-1:0] alu_b, alu_res;
  logic [DATA_WIDTH:0]   sum;
  logic                  alu_c, alu_wr, alu_wr_c, cin;

  assign alu_b = (state_q == StData) ? mem_rdata : imm_data;
  assign cin   = (op == OpAdc) & carry_q;

  always_comb begin
    alu_res  = acc_q;
    alu_c    = carry_q;
    alu_wr   = 1'b0;
    alu_wr_c = 1'b0;
    sum      = '0;
    case (op)
      OpLoad: begin
        alu_res = alu_b;
        alu_wr  = 1'b1;
      end
      OpAdd, OpAdc: begin
        sum      = {1'b0, acc_q} + {1'b0, alu_b} + {{DATA_WIDTH{1'b0}}, cin};
        alu_res  = sum[DATA_WIDTH-1:0];
        alu_c    = sum[DATA_WIDTH];
        alu_wr   = 1'b1;
        alu_wr_c = 1'b1;
      end
      OpSub: begin
        alu_res  = acc_q - alu_b;
        alu_c    = (acc_q >= alu_b);
        alu_wr   = 1'b1;
        alu_wr_c = 1'b1;
      end
      OpAnd: begin
        alu_res = acc_q & alu_b;
        alu_wr  = 1'b1;
      end
      OpOr: begin
        alu_res = acc_q | alu_b;
        alu_wr  = 1'b1;
      end
      OpXor: begin
        alu_res = acc_q ^ alu_b;
        alu_wr  = 1'b1;
      end
      OpNot: begin
        alu_res = ~acc_q;
        alu_wr  = 1'b1;
      end
      OpIn: begin
        alu_res = din_data;
        alu_wr  = 1'b1;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run || step) state_d = StFetch;
      StFetch: if (mem_ready) state_d = StExec;
      StExec: begin
        if (skip_q) begin
          state_d = StIdle;
        end else if (illegal) begin
          state_d = StTrap;
        end else if (op == OpHalt) begin
          state_d = StHalt;
        end else if (has_operand && (mode == 2'd1)) begin
          state_d = StData;
        end else if (has_operand && (mode == 2'd2)) begin
          state_d = StPtr;
        end else begin
          state_d = StIdle;
        end
      end
      StPtr:   if (mem_ready) state_d = StData;
      StData:  if (mem_ready) state_d = StIdle;
      StHalt:  state_d = StHalt;
      StTrap:  state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; request fields derive from held registers so they stay stable until ready
  always_comb begin
    busy      = 1'b0;
    halt      = 1'b0;
    trap      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StFetch: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      StExec: busy = 1'b1;
      StPtr: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = dir_addr;
      end
      StData: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = ea_q;
        if (op == OpStore) begin
          mem_we    = 1'b1;
          mem_wdata = acc_q;
        end
      end
      StHalt:  halt = 1'b1;
      StTrap:  trap = 1'b1;
      default: ;
    endcase
  end

  assign pc_out   = pc_q;
  assign data_out = dout_q;

  // Datapath next-state
  logic alu_en;

  always_comb begin
    pc_d      = pc_q;
    ea_d      = ea_q;
    acc_d     = acc_q;
    inst_d    = inst_q;
    dout_d    = dout_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    skip_d    = skip_q;
    skipped_d = skipped_q;
    alu_en    = 1'b0;
    unique case (state_q)
      StFetch: if (mem_ready) inst_d = mem_rdata;
      StExec: begin
        skipped_d = skip_q;
        skip_d    = 1'b0;
        if (skip_q) begin
          pc_d = pc_inc;
        end else if (!illegal) begin
          pc_d = (op == OpBr) ? br_target : pc_inc;
          if (op == OpIf) skip_d = if_cond;
          if (op == OpOut) dout_d = acc_q[OUT_WIDTH-1:0];
          if (!has_operand || (mode == 2'd0)) alu_en = 1'b1;
          if (has_operand && (mode == 2'd1)) ea_d = dir_addr;
        end
      end
      StPtr:  if (mem_ready) ea_d = ptr_addr;
      StData: if (mem_ready && (op != OpStore)) alu_en = 1'b1;
      default: ;
    endcase
    if (alu_en && alu_wr) begin
      acc_d  = alu_res;
      zero_d = (alu_res == '0);
    end
    if (alu_en && alu_wr_c) carry_d = alu_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= '0;
      ea_q      <= '0;
      acc_q     <= '0;
      inst_q    <= '0;
      dout_q    <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      skip_q    <= 1'b0;
      skipped_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ea_q      <= ea_d;
      acc_q     <= acc_d;
      inst_q    <= inst_d;
      dout_q    <= dout_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      skip_q    <= skip_d;
      skipped_q <= skipped_d;
    end
  end

endmodule

// File: tb/tb_acc_cpu_param.sv
// Bench for acc_cpu_param: instruction-level reference model, memory responder with
// random ready delays, and directed programs with hand-computed results.
module tb_acc_cpu_param;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst_n, step, run, busy, halt, trap;
  logic [AW-1:0] pc_out, mem_addr;
  logic [OW-1:0] data_in, data_out;
  logic          mem_req, mem_we, mem_ready;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  acc_cpu_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .run(run), .busy(busy), .halt(halt),
    .trap(trap), .pc_out(pc_out), .data_in(data_in), .data_out(data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {int addr; bit we; int wdata;} txn_t;
  typedef struct {int pc; int dout; bit h; bit t;} snap_t;

  int          total = 0;
  int          bad = 0;
  logic [15:0] dm [0:65535];
  logic [15:0] mm [0:65535];
  txn_t        exp_txn[$];
  snap_t       exp_snap[$];
  bit          chk_en = 1'b0;
  bit          step_rand = 1'b0;
  int          delay_mode = 0;
  int          txn_cnt = 0;
  int          we_cnt = 0;
  int          addr5_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: whole-instruction semantics, producing expected bus traffic and
  // the architectural view after each instruction.
  task automatic run_model(input int max_n, input int din);
    int pc = 0, acc = 0, dout = 0, n = 0;
    int inst, op, mode, imm, opnd, ea, s;
    bit z = 0, c = 0, sk = 0, skd = 0, old_sk, old_skd, h = 0, t = 0, isop;
    txn_t tx;
    snap_t sn;
    while (n < max_n && !h && !t) begin
      tx.addr = pc; tx.we = 0; tx.wdata = 0;
      exp_txn.push_back(tx);
      inst = int'(mm[pc]);
      op = inst >> 12; mode = (inst >> 10) & 3; imm = inst & 'h3FF;
      old_sk = sk; old_skd = skd; skd = sk; sk = 0;
      isop = op inside {2, 3, 4, 5, 6, 7, 8, 13};
      if (old_sk) begin
        pc = (pc + 1) & 'hFFFF;
      end else if (op == 15 || (isop && (mode == 3 || (op == 3 && mode == 0)))) begin
        t = 1;
      end else begin
        opnd = imm;
        if (isop && mode != 0) begin
          ea = imm;
          if (mode == 2) begin
            tx.addr = imm; tx.we = 0; tx.wdata = 0;
            exp_txn.push_back(tx);
            ea = int'(mm[imm]);
          end
          if (op == 3) begin
            tx.addr = ea; tx.we = 1; tx.wdata = acc;
            exp_txn.push_back(tx);
            mm[ea] = 16'(acc);
          end else begin
            tx.addr = ea; tx.we = 0; tx.wdata = 0;
            exp_txn.push_back(tx);
            opnd = int'(mm[ea]);
          end
        end
        case (op)
          1:  h = 1;
          2:  acc = opnd;
          4:  begin s = acc + opnd; c = (s > 'hFFFF); acc = s & 'hFFFF; end
          13: begin s = acc + opnd + int'(c); c = (s > 'hFFFF); acc = s & 'hFFFF; end
          5:  begin c = (acc >= opnd); acc = (acc - opnd) & 'hFFFF; end
          6:  acc = acc & opnd;
          7:  acc = acc | opnd;
          8:  acc = acc ^ opnd;
          9:  acc = ~acc & 'hFFFF;
          11: case (imm & 3)
                0: sk = !z;
                1: sk = z;
                2: sk = !c;
                default: sk = !old_skd;
              endcase
          12: dout = acc & 'hFF;
          14: acc = din;
          default: ;
        endcase
        if (op inside {2, 4, 5, 6, 7, 8, 9, 13, 14}) z = (acc == 0);
        if (op == 10) pc = (pc + 1 + ((imm >= 512) ? imm - 1024 : imm)) & 'hFFFF;
        else pc = (pc + 1) & 'hFFFF;
      end
      sn.pc = pc; sn.dout = dout; sn.h = h; sn.t = t;
      exp_snap.push_back(sn);
      n++;
    end
  endtask

  // Memory responder plus the per-cycle compare against the model.
  initial begin : resp
    int          wait_cnt, cur_delay;
    bit          prev_wait, prev_busy;
    logic [15:0] p_addr, p_wdata;
    logic        p_we;
    txn_t        t;
    snap_t       s;
    wait_cnt = 0; cur_delay = 0; prev_wait = 0; prev_busy = 0;
    p_addr = 0; p_wdata = 0; p_we = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wait_cnt = 0; prev_wait = 0; prev_busy = 0;
        mem_ready = 1'b0;
      end else begin
        if (step_rand) step = ($urandom_range(0, 2) == 0);
        if (chk_en && prev_busy && !busy) begin
          if (exp_snap.size() == 0) begin
            chk("extra_instr", 1, 0);
          end else begin
            s = exp_snap.pop_front();
            if (!s.t) chk("pc_out", pc_out, s.pc);
            chk("data_out", data_out, s.dout);
            chk("halt", halt, s.h);
            chk("trap", trap, s.t);
            if (exp_snap.size() == 0) chk_en = 1'b0;
          end
        end
        prev_busy = busy;
        if (mem_req && prev_wait) begin
          chk("hold_addr", mem_addr, p_addr);
          chk("hold_we", mem_we, p_we);
          chk("hold_wdata", mem_wdata, p_wdata);
        end
        mem_ready = 1'b0;
        if (mem_req) begin
          if (wait_cnt == 0) cur_delay = (delay_mode < 0) ? $urandom_range(0, 3) : delay_mode;
          if (wait_cnt >= cur_delay) begin
            mem_ready = 1'b1;
            wait_cnt = 0;
            txn_cnt++;
            if (mem_addr == 5) addr5_cnt++;
            if (mem_we) begin
              we_cnt++;
              dm[mem_addr] = mem_wdata;
            end else begin
              mem_rdata = dm[mem_addr];
            end
            if (chk_en) begin
              if (exp_txn.size() == 0) begin
                chk("extra_txn", 1, 0);
              end else begin
                t = exp_txn.pop_front();
                chk("txn_addr", mem_addr, t.addr);
                chk("txn_we", mem_we, t.we);
                if (t.we) chk("txn_wdata", mem_wdata, t.wdata);
              end
            end
          end else begin
            wait_cnt++;
          end
        end
        prev_wait = mem_req && !mem_ready;
        p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin
      dm[i] = '0;
      mm[i] = '0;
    end
  endtask

  task automatic put(input int a, input logic [15:0] w);
    dm[a] = w;
    mm[a] = w;
  endtask

  task automatic do_reset();
    chk_en = 1'b0; step_rand = 1'b0; run = 1'b0; step = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_txn.delete();
    exp_snap.delete();
    txn_cnt = 0; we_cnt = 0; addr5_cnt = 0;
    rst_n = 1'b1;
  endtask

  task automatic go(input int max_n, input int din, input int dly, input bit use_run,
                    input bit srand, input int budget);
    int i;
    data_in = OW'(din);
    delay_mode = dly;
    run_model(max_n, din);
    chk_en = 1'b1;
    step_rand = srand;
    run = use_run;
    for (i = 0; i < budget && exp_snap.size() != 0; i++) @(negedge clk);
    if (exp_snap.size() != 0) chk("timeout_instr_left", exp_snap.size(), 0);
    chk("txn_left", exp_txn.size(), 0);
    chk_en = 1'b0;
    run = 1'b0;
    step_rand = 1'b0;
    step = 1'b0;
  endtask

  function automatic logic [15:0] gen_inst();
    int ops[14] = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    int r, op, mode, imm;
    r = $urandom_range(0, 99);
    if (r < 2) op = 1;
    else if (r < 3) op = 15;
    else op = ops[$urandom_range(0, 13)];
    mode = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
    if (op == 3 && mode == 0 && $urandom_range(0, 9) != 0) mode = 1;
    imm = $urandom_range(0, 1023);
    if (op == 10) imm = ($urandom_range(0, 23) - 8) & 'h3FF;
    return 16'((op << 12) | (mode << 10) | imm);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    logic [15:0] w;
    rst_n = 1'b0; step = 1'b0; run = 1'b0; data_in = '0;
    clear_mem();
    do_reset();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_halt", halt, 0);
    chk("rst_trap", trap, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);

    // LOAD#5, ADD#3, OUT, HALT
    clear_mem();
    put(0, 16'h2005); put(1, 16'h4003); put(2, 16'hC000); put(3, 16'h1000);
    do_reset();
    go(10, 0, 0, 1'b1, 1'b0, 200);
    chk("t1_dout", data_out, 8'h08);
    chk("t1_halt", halt, 1);
    chk("t1_busy", busy, 0);
    chk("t1_pc", pc_out, 4);
    chk("t1_fetches", txn_cnt, 4);

    // NOT / ADD carry-out / ADC, results exposed through stores
    clear_mem();
    put(0, 16'h2000); put(1, 16'h9000); put(2, 16'h3430); put(3, 16'h4001);
    put(4, 16'h3431); put(5, 16'hD000); put(6, 16'h3432); put(7, 16'h1000);
    do_reset();
    go(20, 0, -1, 1'b1, 1'b0, 400);
    chk("t2_not", dm[16'h30], 16'hFFFF);
    chk("t2_add", dm[16'h31], 16'h0000);
    chk("t2_adc", dm[16'h32], 16'h0001);

    // Indirect LOAD then direct STORE with slow memory
    clear_mem();
    put(0, 16'h2810); put(1, 16'h3430); put(2, 16'h1000);
    put(16'h10, 16'h0020); put(16'h20, 16'h1234);
    do_reset();
    go(10, 0, 3, 1'b1, 1'b0, 400);
    chk("t3_store", dm[16'h30], 16'h1234);
    chk("t3_txns", txn_cnt, 6);

    // IF zero skips, IF else does not
    clear_mem();
    put(0, 16'h2003); put(1, 16'hB000); put(2, 16'h2007); put(3, 16'hB003);
    put(4, 16'h2009); put(5, 16'h3430); put(6, 16'h1000);
    do_reset();
    go(20, 0, 0, 1'b1, 1'b0, 400);
    chk("t4_acc", dm[16'h30], 16'h0009);
    chk("t4_txns", txn_cnt, 8);

    // Single-step a self-branch
    clear_mem();
    put(0, 16'hA004); put(5, 16'hA3FF);
    do_reset();
    delay_mode = 0;
    run_model(4, 0);
    chk_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      for (i = 0; i < 20 && busy; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("t5_idle_busy", busy, 0);
      chk("t5_pc", pc_out, 5);
    end
    chk("t5_fetch5", addr5_cnt, 3);
    chk("t5_txns", txn_cnt, 4);
    chk_en = 1'b0;

    // STORE immediate traps without writing
    clear_mem();
    put(0, 16'h3000);
    do_reset();
    go(5, 0, 0, 1'b1, 1'b0, 100);
    repeat (3) @(negedge clk);
    chk("t6_trap", trap, 1);
    chk("t6_busy", busy, 0);
    chk("t6_writes", we_cnt, 0);

    // Reset while a fetch is stalled
    clear_mem();
    put(0, 16'h2005);
    do_reset();
    delay_mode = 1000;
    run = 1'b1;
    for (i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("t6_fetch_seen", mem_req, 1);
    rst_n = 1'b0;
    run = 1'b0;
    @(negedge clk);
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_pc", pc_out, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_dout", data_out, 0);
    rst_n = 1'b1;
    delay_mode = 0;

    // Random programs, free-running and randomly stepped
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 65536; a++) begin
        w = (a < 1024) ? gen_inst() : 16'($urandom);
        dm[a] = w;
        mm[a] = w;
      end
      do_reset();
      go(60, int'($urandom_range(0, 255)), -1, (r < 3), (r >= 3), 5000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
